// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// the x0 register index and the NOP word loaded by flushed pipeline registers.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    IMEM_WAIT  = 2'd2
  } fetch_state_e;

  localparam logic [4:0]  REG_X0   = 5'd0;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the pipeline (master) and the fetch sequencer (slave):
// hazard/resolution inputs towards the sequencer, stall/flush/redirect controls back.
interface fetch_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  import fetch_sequencer_pkg::*;

  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            ex_mem_read;
  logic [4:0]      ex_rd;
  logic            ex_branch_taken;
  logic            ex_jump_taken;
  logic            ex_jalr_taken;
  logic [XLEN-1:0] ex_target;
  logic            imem_ready;

  logic            stall_pc;
  logic            stall_ifid;
  logic            bubble_idex;
  logic            flush_ifid;
  logic            flush_idex;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            misalign_err;

  modport master (
    output id_valid, id_rs1, id_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, ex_jump_taken, ex_jalr_taken, ex_target, imem_ready,
    input  stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex,
           redirect_valid, redirect_pc, misalign_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, ex_jump_taken, ex_jalr_taken, ex_target, imem_ready,
    output stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex,
           redirect_valid, redirect_pc, misalign_err
  );

endinterface

// File: rtl/fetch_sequencer_hazard_detect.sv
// Combinational load-use detector: a load in EX writing a register that the
// instruction in ID reads, suppressed while wrong-path slots are being squashed.
module fetch_hazard_detect
  import fetch_sequencer_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       squash_idle,
  output logic       load_use
);

  always_comb begin
    load_use = id_valid && ex_mem_read && (ex_rd != REG_X0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2)) && squash_idle;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: arbitrates redirects, instruction-memory waits and load-use
// stalls into PC/IF/ID/EX controls. Define FETCH_SEQ_PERF_EN to add performance counters.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     SQUASH_CYCLES = 2,
  parameter logic [XLEN-1:0] RESET_PC      = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_sequencer_if.slave bus
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_redirect_cnt,
  output logic [31:0]      perf_imem_wait_cnt
`endif
);

  localparam int unsigned SQW = (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);

  fetch_state_e    state_q, state_d;
  logic [SQW-1:0]  squash_cnt_q, squash_cnt_d;
  logic            pending_q, pending_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic            misalign_q, misalign_d;

  logic            any_taken;
  logic [XLEN-1:0] tgt;
  logic            load_use;

  logic            stall_pc_c, stall_ifid_c, bubble_idex_c;
  logic            flush_ifid_c, flush_idex_c, redirect_valid_c;
  logic [XLEN-1:0] redirect_pc_c;

  fetch_hazard_detect u_hazard (
    .id_valid    (bus.id_valid),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .squash_idle (squash_cnt_q == '0),
    .load_use    (load_use)
  );

  always_comb begin
    tgt = bus.ex_target;
    if (bus.ex_jalr_taken) tgt[0] = 1'b0;
    any_taken = bus.ex_branch_taken || bus.ex_jump_taken || bus.ex_jalr_taken;
  end

  always_comb begin
    state_d          = state_q;
    squash_cnt_d     = squash_cnt_q;
    pending_d        = pending_q;
    pending_pc_d     = pending_pc_q;
    misalign_d       = misalign_q;
    stall_pc_c       = 1'b0;
    stall_ifid_c     = 1'b0;
    bubble_idex_c    = 1'b0;
    flush_ifid_c     = 1'b0;
    flush_idex_c     = 1'b0;
    redirect_valid_c = 1'b0;
    redirect_pc_c    = RESET_PC;

    if ((state_q == RUN) && (squash_cnt_q != '0)) squash_cnt_d = squash_cnt_q - 1'b1;

    // Priority: redirect, then memory wait, then pending release, then load-use.
    if (any_taken && bus.imem_ready) begin
      redirect_valid_c = 1'b1;
      redirect_pc_c    = tgt;
      flush_ifid_c     = 1'b1;
      flush_idex_c     = 1'b1;
      pending_d        = 1'b0;
      squash_cnt_d     = SQW'(SQUASH_CYCLES);
      state_d          = RUN;
    end else if (any_taken) begin
      pending_d    = 1'b1;
      pending_pc_d = tgt;
      stall_pc_c   = 1'b1;
      flush_ifid_c = 1'b1;
      flush_idex_c = 1'b1;
      state_d      = IMEM_WAIT;
    end else if (!bus.imem_ready) begin
      stall_pc_c   = 1'b1;
      flush_ifid_c = 1'b1;
      state_d      = IMEM_WAIT;
    end else if (state_q == IMEM_WAIT) begin
      state_d = RUN;
      if (pending_q) begin
        redirect_valid_c = 1'b1;
        redirect_pc_c    = pending_pc_q;
        pending_d        = 1'b0;
        squash_cnt_d     = SQW'(SQUASH_CYCLES);
      end
    end else if ((state_q == RUN) && load_use) begin
      stall_pc_c    = 1'b1;
      stall_ifid_c  = 1'b1;
      bubble_idex_c = 1'b1;
      state_d       = LOAD_STALL;
    end else begin
      state_d = RUN;
    end

    if (redirect_valid_c && (redirect_pc_c[1:0] != 2'b00)) misalign_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      squash_cnt_q <= '0;
      pending_q    <= 1'b0;
      pending_pc_q <= RESET_PC;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      squash_cnt_q <= squash_cnt_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  // Outputs are forced idle while reset is held, whatever the inputs do.
  assign bus.stall_pc       = rst_n && stall_pc_c;
  assign bus.stall_ifid     = rst_n && stall_ifid_c;
  assign bus.bubble_idex    = rst_n && bubble_idex_c;
  assign bus.flush_ifid     = rst_n && flush_ifid_c;
  assign bus.flush_idex     = rst_n && flush_idex_c;
  assign bus.redirect_valid = rst_n && redirect_valid_c;
  assign bus.redirect_pc    = rst_n ? redirect_pc_c : RESET_PC;
  assign bus.misalign_err   = rst_n && misalign_q;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_redir_q, perf_redir_d;
  logic [31:0] perf_wait_q,  perf_wait_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall_pc_c};
    perf_redir_d = perf_redir_q + {31'd0, redirect_valid_c};
    perf_wait_d  = perf_wait_q  + {31'd0, ~bus.imem_ready};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_redir_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_redir_q <= perf_redir_d;
      perf_wait_q  <= perf_wait_d;
    end
  end

  assign perf_stall_cnt     = perf_stall_q;
  assign perf_redirect_cnt  = perf_redir_q;
  assign perf_imem_wait_cnt = perf_wait_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written corner sequences,
// then randomized cycles compared against a cycle-level behavioural model.
module tb_fetch_sequencer;
  localparam int SQ = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.XLEN(32)) bus ();

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_stall_cnt, perf_redirect_cnt, perf_imem_wait_cnt;
`endif

  fetch_sequencer #(.XLEN(32), .SQUASH_CYCLES(SQ), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .perf_stall_cnt     (perf_stall_cnt),
    .perf_redirect_cnt  (perf_redirect_cnt),
    .perf_imem_wait_cnt (perf_imem_wait_cnt)
`endif
  );

  // flags = {stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, redirect_valid, misalign_err}
  typedef struct {
    logic        rst_n;
    logic        idv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        mr;
    logic [4:0]  rd;
    logic        br;
    logic        jp;
    logic        jr;
    logic [31:0] tgt;
    logic        rdy;
    logic [6:0]  exp_flags;
    logic [31:0] exp_pc;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Model state: what the previous cycle did, plus pending redirect and squash window.
  bit          m_waiting, m_just_stalled, m_pend, m_mis;
  logic [31:0] m_pend_pc;
  int          m_squash;

  function automatic vec_t mk(bit r, bit idv, int rs1, int rs2, bit mr, int rd,
                              bit br, bit jp, bit jr, logic [31:0] t, bit rdy,
                              logic [6:0] f, logic [31:0] pc);
    vec_t v;
    v.rst_n = r; v.idv = idv; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.mr = mr; v.rd = 5'(rd);
    v.br = br; v.jp = jp; v.jr = jr; v.tgt = t; v.rdy = rdy;
    v.exp_flags = f; v.exp_pc = pc;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model(input vec_t v, output logic [6:0] f, output logic [31:0] pc);
    bit any, hz, in_run, sp, si, bu, fi, fe, rv, nwait, nstall;
    logic [31:0] t;
    int nsq;
    any = v.br || v.jp || v.jr;
    t = v.tgt;
    if (v.jr) t[0] = 1'b0;
    in_run = !m_waiting && !m_just_stalled;
    hz = v.idv && v.mr && (v.rd != 0) && (v.rd == v.rs1 || v.rd == v.rs2) && (m_squash == 0);
    {sp, si, bu, fi, fe, rv, nwait, nstall} = '0;
    pc = 32'h0;
    nsq = (in_run && m_squash > 0) ? m_squash - 1 : m_squash;
    if (!v.rst_n) begin
      f = '0;
      m_waiting = 0; m_just_stalled = 0; m_pend = 0; m_mis = 0; m_squash = 0; m_pend_pc = 0;
    end else begin
      if (any && v.rdy) begin
        rv = 1; pc = t; fi = 1; fe = 1; m_pend = 0; nsq = SQ;
      end else if (any) begin
        m_pend = 1; m_pend_pc = t; sp = 1; fi = 1; fe = 1; nwait = 1;
      end else if (!v.rdy) begin
        sp = 1; fi = 1; nwait = 1;
      end else if (m_waiting) begin
        if (m_pend) begin rv = 1; pc = m_pend_pc; m_pend = 0; nsq = SQ; end
      end else if (in_run && hz) begin
        sp = 1; si = 1; bu = 1; nstall = 1;
      end
      f = {sp, si, bu, fi, fe, rv, m_mis};
      if (rv && pc[1:0] != 2'b00) m_mis = 1;
      m_waiting = nwait; m_just_stalled = nstall; m_squash = nsq;
    end
  endtask

  // Entered just after a posedge; inputs settle, outputs sampled on the negedge.
  task automatic apply(input vec_t v, input string nm, input bit use_model);
    logic [6:0]  mf, gf;
    logic [31:0] mpc;
    rst_n = v.rst_n;
    bus.id_valid = v.idv; bus.id_rs1 = v.rs1; bus.id_rs2 = v.rs2;
    bus.ex_mem_read = v.mr; bus.ex_rd = v.rd;
    bus.ex_branch_taken = v.br; bus.ex_jump_taken = v.jp; bus.ex_jalr_taken = v.jr;
    bus.ex_target = v.tgt; bus.imem_ready = v.rdy;
    @(negedge clk);
    model(v, mf, mpc);
    gf = {bus.stall_pc, bus.stall_ifid, bus.bubble_idex, bus.flush_ifid,
          bus.flush_idex, bus.redirect_valid, bus.misalign_err};
    if (use_model) begin
      check({nm, " flags"}, {25'd0, gf}, {25'd0, mf});
      check({nm, " pc"}, bus.redirect_pc, mpc);
    end else begin
      check({nm, " flags"}, {25'd0, gf}, {25'd0, v.exp_flags});
      check({nm, " pc"}, bus.redirect_pc, v.exp_pc);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.ex_mem_read = 0; bus.ex_rd = 0;
    bus.ex_branch_taken = 0; bus.ex_jump_taken = 0; bus.ex_jalr_taken = 0;
    bus.ex_target = 0; bus.imem_ready = 1;

    //             r idv rs1 rs2 mr rd br jp jr target        rdy flags       pc
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));
    tbl.push_back(mk(1, 1, 5, 0, 1, 5, 0, 0, 0, 32'h0,       1, 7'b1110000, 32'h0));
    tbl.push_back(mk(1, 1, 5, 0, 1, 5, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));
    tbl.push_back(mk(1, 1, 5, 0, 1, 0, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h41,      1, 7'b0001110, 32'h40));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h100,     0, 7'b1001100, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       0, 7'b1001000, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       0, 7'b1001000, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000010, 32'h100));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));
    tbl.push_back(mk(1, 1, 5, 0, 1, 5, 0, 1, 0, 32'h80,      1, 7'b0001110, 32'h80));
    tbl.push_back(mk(1, 1, 5, 0, 1, 5, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));
    tbl.push_back(mk(1, 1, 0, 5, 1, 5, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));
    tbl.push_back(mk(1, 1, 0, 5, 1, 5, 0, 0, 0, 32'h0,       1, 7'b1110000, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h22,      1, 7'b0001110, 32'h22));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000001, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000001, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 32'h203,     1, 7'b0001110, 32'h202));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000001, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1, 7'b0000000, 32'h0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i), 1'b0);

    // Youngest resolution overwrites a pending redirect.
    apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h100, 0, 7'b1001100, 32'h0),   "ovr0", 1'b0);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h200, 0, 7'b1001100, 32'h0),   "ovr1", 1'b0);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 7'b0000010, 32'h200), "ovr2", 1'b0);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 7'b0000000, 32'h0),   "ovr3", 1'b0);
    // Reset while a redirect is pending discards it.
    apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h300, 0, 7'b1001100, 32'h0),   "rstp0", 1'b0);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 7'b0000000, 32'h0),   "rstp1", 1'b0);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 7'b0000000, 32'h0),   "rstp2", 1'b0);
    // Redirect arriving during the load-stall cycle wins.
    apply(mk(1, 1, 7, 0, 1, 7, 0, 0, 0, 32'h0,   1, 7'b1110000, 32'h0),   "lsr0", 1'b0);
    apply(mk(1, 1, 7, 0, 1, 7, 1, 0, 0, 32'h400, 1, 7'b0001110, 32'h400), "lsr1", 1'b0);

    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 7'b0, 32'h0), "rnd_rst0", 1'b1);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 7'b0, 32'h0), "rnd_rst1", 1'b1);
    for (int n = 0; n < 3000; n++) begin
      rv.rst_n = ($urandom_range(0, 99) != 0);
      rv.idv   = $urandom_range(0, 3) != 0;
      rv.rs1   = 5'($urandom_range(0, 3));
      rv.rs2   = 5'($urandom_range(0, 3));
      rv.mr    = $urandom_range(0, 1) == 1;
      rv.rd    = 5'($urandom_range(0, 3));
      rv.br    = $urandom_range(0, 9) == 0;
      rv.jp    = $urandom_range(0, 14) == 0;
      rv.jr    = $urandom_range(0, 14) == 0;
      rv.tgt   = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      rv.rdy   = $urandom_range(0, 4) != 0;
      rv.exp_flags = '0;
      rv.exp_pc    = '0;
      apply(rv, $sformatf("rnd%0d", n), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
